drum_word_reader: RTL and testbench

- Host-side reader for the G-15 drum lines M0–M6.
- Takes a (line, word) request. Waits for that word to pass the read head. Deserialises its 29 bits from the selected recirculating track into a parallel word. Returns the word over a valid/ready response channel.
- Sits between the memory block outputs and the FPGA host/debug interface. It is the read side, complementing the LB-driven track write logic.

---
 rtl/g15_pkg.sv | 25 ++
 rtl/word_deser.sv | 43 ++++
 rtl/drum_word_reader.sv | 113 +++++++++++
 tb/tb_drum_word_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/g15_pkg.sv
// Shared constants and types for the G-15 drum read path.
package g15_pkg;

    localparam int WORD_BITS      = 29;
    localparam int WORDS_PER_LINE = 108;
    localparam int NUM_LINES      = 7;
    localparam int TIMEOUT_WORDS  = 216;

    typedef logic [WORD_BITS-1:0] drum_word_t;
    typedef logic [4:0]           bit_count_t;
    typedef logic [7:0]           timeout_count_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        RESP
    } rd_state_t;

    // True when a (line, word) request addresses a word that exists on the drum.
    function automatic logic req_in_range(input logic [2:0] line, input logic [6:0] word);
        return (32'(line) < NUM_LINES) && (32'(word) < WORDS_PER_LINE);
    endfunction

endpackage

// File: rtl/word_deser.sv
// Serial-in / parallel-out register for one drum word. Bit 0 is the first
// bit off the drum. The final bit is not stored: it is merged combinationally
// into word so the caller can register the complete word on the same edge
// that the last bit arrives.
module word_deser
    import g15_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic       bit_in,
    output drum_word_t word,
    output logic       done
);

    logic [WORD_BITS-2:0] data_q;
    bit_count_t           count_q;

    // Bit 0 restarts the word; each following shift fills the next position.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            data_q  <= '0;
            count_q <= '0;
        end else if (load) begin
            data_q    <= '0;
            data_q[0] <= bit_in;
            count_q   <= 5'd1;
        end else if (shift) begin
            if (count_q < 5'(WORD_BITS - 1)) begin
                data_q[count_q] <= bit_in;
            end
            if (count_q < 5'(WORD_BITS)) begin
                count_q <= count_q + 5'd1;
            end
        end
    end

    assign done = shift && (count_q == 5'(WORD_BITS - 1));
    assign word = {bit_in, data_q};

endmodule

// File: rtl/drum_word_reader.sv
// Host-side reader for drum lines M0..M6: waits for the requested word to
// reach the read head, deserialises it and returns it on a valid/ready channel.
module drum_word_reader
    import g15_pkg::*;
(
    input  logic             CLOCK,
    input  logic             rst_n,
    input  logic [6:0]       M_LINES,
    input  logic             WORD_START,
    input  logic [6:0]       WORD_NUM,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_line,
    input  logic [6:0]       req_word,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output drum_word_t       rsp_data,
    output logic             rsp_err
);

    rd_state_t      state_q;
    logic [2:0]     line_q;
    logic [6:0]     word_q;
    timeout_count_t timeout_q;

    logic       head_bit;
    logic       target_hit;
    logic       deser_done;
    drum_word_t deser_word;

    assign head_bit   = M_LINES[line_q];
    assign target_hit = (state_q == WAIT) && WORD_START && (WORD_NUM == word_q);

    word_deser u_deser (
        .clk    (CLOCK),
        .rst_n  (rst_n),
        .load   (target_hit),
        .shift  (state_q == SHIFT),
        .bit_in (head_bit),
        .word   (deser_word),
        .done   (deser_done)
    );

    // Request/response FSM with registered handshake outputs.
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            line_q    <= '0;
            word_q    <= '0;
            timeout_q <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        line_q    <= req_line;
                        word_q    <= req_word;
                        req_ready <= 1'b0;
                        if (req_in_range(req_line, req_word)) begin
                            state_q   <= WAIT;
                            timeout_q <= '0;
                        end else begin
                            state_q   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (target_hit) begin
                        state_q <= SHIFT;
                    end else if (WORD_START) begin
                        // The target never showed up within two revolutions.
                        if (timeout_q == 8'(TIMEOUT_WORDS - 1)) begin
                            state_q   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end
                        if (timeout_q != 8'hFF) begin
                            timeout_q <= timeout_q + 8'd1;
                        end
                    end
                end
                SHIFT: begin
                    if (deser_done) begin
                        state_q   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= deser_word;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q   <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drum_word_reader.sv
// Directed bench for drum_word_reader with a behavioural rotating drum.
module tb_drum_word_reader;

    logic        CLOCK;
    logic        rst_n;
    logic [6:0]  M_LINES;
    logic        WORD_START;
    logic [6:0]  WORD_NUM;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_line;
    logic [6:0]  req_word;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [28:0] rsp_data;
    logic        rsp_err;

    drum_word_reader dut (
        .CLOCK      (CLOCK),
        .rst_n      (rst_n),
        .M_LINES    (M_LINES),
        .WORD_START (WORD_START),
        .WORD_NUM   (WORD_NUM),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_line   (req_line),
        .req_word   (req_word),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drum model: contents, head position, and an optional suppressed word start.
    logic [28:0] mem [7][108];
    int bit_pos;
    int word_pos;
    int suppress;

    task automatic drive_drum();
        WORD_START = (bit_pos == 0) && (word_pos != suppress);
        WORD_NUM   = 7'(word_pos);
        for (int l = 0; l < 7; l++) begin
            M_LINES[l] = mem[l][word_pos][bit_pos];
        end
    endtask

    initial begin
        for (int l = 0; l < 7; l++) begin
            for (int w = 0; w < 108; w++) begin
                mem[l][w] = 29'((l * 32'h0123_4567) ^ (w * 32'h00F0_F0F1) ^ 32'h0A5A_5A5A);
            end
        end
        mem[2][5]   = 29'h0ABCDEF;
        mem[2][4]   = 29'h1234567;
        mem[2][6]   = 29'h0765432;
        mem[3][20]  = 29'h15555555;
        mem[4][0]   = 29'h10000001;
        mem[6][100] = 29'h00F0F0F0;
        suppress = -1;
        bit_pos  = 0;
        word_pos = 0;
        drive_drum();
        forever begin
            @(posedge CLOCK);
            #1;
            if (bit_pos == 28) begin
                bit_pos  = 0;
                word_pos = (word_pos == 107) ? 0 : word_pos + 1;
            end else begin
                bit_pos++;
            end
            drive_drum();
        end
    end

    // Advance to the negedge inside the cycle where the head sits on (w, b).
    task automatic wait_drum(input int w, input int b);
        int n;
        n = 0;
        @(negedge CLOCK);
        while (!(word_pos == w && bit_pos == b) && n < 4000) begin
            @(negedge CLOCK);
            n++;
        end
        if (n >= 4000) check("drum_sync", 32'(n), 32'd0);
    endtask

    // Present a request for one cycle; called at a negedge.
    task automatic send_req(input logic [2:0] line, input logic [6:0] word);
        req_valid = 1'b1;
        req_line  = line;
        req_word  = word;
        @(negedge CLOCK);
        req_valid = 1'b0;
    endtask

    // Count cycles from the request cycle until rsp_valid, bounded.
    task automatic wait_rsp(input int limit, output int n);
        n = 1;
        while (!rsp_valid && n < limit) begin
            @(negedge CLOCK);
            n++;
        end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge CLOCK);
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    int n;
    int bad;
    logic [28:0] held;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_line  = '0;
        req_word  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge CLOCK);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data",  32'(rsp_data),  32'd0);
        check("reset_rsp_err",   32'(rsp_err),   32'd0);
        rst_n = 1'b1;

        // Basic read: line 2 word 5, requested while word 0 is under the head.
        wait_drum(0, 0);
        send_req(3'd2, 7'd5);
        wait_rsp(8000, n);
        check("basic_latency", 32'(n), 32'd174);
        check("basic_data", 32'(rsp_data), 32'h00ABCDEF);
        check("basic_err", 32'(rsp_err), 32'd0);
        check("basic_req_ready_busy", 32'(req_ready), 32'd0);
        finish_rsp("basic");

        // Wrap: word 0 under the head at acceptance is read a revolution later.
        wait_drum(0, 0);
        send_req(3'd4, 7'd0);
        wait_rsp(8000, n);
        check("wrap_latency", 32'(n), 32'd3161);
        check("wrap_data", 32'(rsp_data), 32'h10000001);
        check("wrap_err", 32'(rsp_err), 32'd0);
        finish_rsp("wrap");

        // Invalid line.
        wait_drum(2, 0);
        send_req(3'd7, 7'd3);
        wait_rsp(8000, n);
        check("bad_line_latency", 32'(n), 32'd1);
        check("bad_line_err", 32'(rsp_err), 32'd1);
        check("bad_line_data", 32'(rsp_data), 32'd0);
        finish_rsp("bad_line");

        // Invalid word.
        wait_drum(2, 0);
        send_req(3'd1, 7'd108);
        wait_rsp(8000, n);
        check("bad_word_latency", 32'(n), 32'd1);
        check("bad_word_err", 32'(rsp_err), 32'd1);
        check("bad_word_data", 32'(rsp_data), 32'd0);
        finish_rsp("bad_word");

        // Timeout: word 5 never announced; 216th other pulse arrives 6321 cycles in.
        suppress = 5;
        wait_drum(6, 1);
        send_req(3'd0, 7'd5);
        wait_rsp(8000, n);
        check("timeout_latency", 32'(n), 32'd6322);
        check("timeout_err", 32'(rsp_err), 32'd1);
        check("timeout_data", 32'(rsp_data), 32'd0);
        finish_rsp("timeout");
        suppress = -1;

        // Backpressure: hold the response while a second request is offered.
        wait_drum(90, 0);
        send_req(3'd6, 7'd100);
        wait_rsp(8000, n);
        check("bp_latency", 32'(n), 32'd319);
        check("bp_data", 32'(rsp_data), 32'h00F0F0F0);
        held = rsp_data;
        bad = 0;
        req_valid = 1'b1;
        req_line  = 3'd1;
        req_word  = 7'd2;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLOCK);
            if (rsp_data !== held || rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_err !== 1'b0) bad++;
        end
        check("bp_hold_violations", 32'(bad), 32'd0);
        req_valid = 1'b0;
        finish_rsp("bp");
        repeat (40) @(negedge CLOCK);
        check("bp_second_req_ignored", 32'(rsp_valid), 32'd0);

        // Reset in the middle of a shift, then reread the same word.
        wait_drum(19, 0);
        send_req(3'd3, 7'd20);
        wait_drum(20, 12);
        rst_n = 1'b0;
        #1;
        check("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_reset_req_ready", 32'(req_ready), 32'd1);
        @(negedge CLOCK);
        rst_n = 1'b1;
        wait_drum(19, 0);
        send_req(3'd3, 7'd20);
        wait_rsp(8000, n);
        check("reread_latency", 32'(n), 32'd58);
        check("reread_data", 32'(rsp_data), 32'h15555555);
        check("reread_err", 32'(rsp_err), 32'd0);
        finish_rsp("reread");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
